seg7_scan_reader: RTL

- Reader for the team's multiplexed 7-segment display interface. It takes a segment bus plus active-low digit anodes and reconstructs the hex digit value shown on each position.
- Used in self-checking benches and in loopback builds, between the display driver outputs and any consumer that needs the displayed value as binary.
- Presents a complete multi-digit frame on a valid/ready handshake and flags glyphs that are not valid hex.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_glyph_decode.sv | 27 ++
 rtl/seg7_scan_reader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and the hex glyph table for 7-segment display
// readers and checkers. Segment bit order is bit0=a ... bit6=g, active-high.
package seg7_pkg;

   typedef logic [6:0] seg7_t;
   typedef logic [3:0] nibble_t;

   // Glyph for each hex value; index is the nibble the pattern represents.
   localparam seg7_t SEG7_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   // All segments dark; never matches a glyph, so it decodes as an error.
   localparam seg7_t SEG7_BLANK = 7'h00;

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: combinational reverse lookup of a 7-segment pattern
// into its hex nibble. Unknown patterns (blank included) give nibble 0 with
// err set. The caller masks off any decimal point before presenting seg.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  seg7_t   seg,
   output nibble_t nibble,
   output logic    err
);

   // Search the glyph table; at most one entry can match.
   always_comb begin
      nibble = 4'h0;
      err    = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG7_GLYPH[i]) begin
            nibble = nibble_t'(i);
            err    = 1'b0;
         end else begin
            nibble = nibble;
            err    = err;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: watches a multiplexed 7-segment bus (segments plus
// active-low anodes), captures each digit once it has been stable for
// STABLE_CYCLES samples, and hands out complete frames on valid/ready.
// Optional build macro SEG7_SCAN_DP_EN adds dp_in / frame_dp: the decimal
// point joins the stability compare and is captured per digit.
module seg7_scan_reader
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [6:0]                seg_in,
   input  logic [NUM_DIGITS-1:0]     an_n_in,
   output logic [4*NUM_DIGITS-1:0]   frame_data,
   output logic [NUM_DIGITS-1:0]     frame_err,
   output logic                      frame_valid,
   input  logic                      frame_ready,
`ifdef SEG7_SCAN_DP_EN
   input  logic                      dp_in,
   output logic [NUM_DIGITS-1:0]     frame_dp,
`endif
   output logic                      overrun
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]         CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]         CNT_ZERO = CW'(0);
   localparam logic [NUM_DIGITS-1:0] D_ZERO   = {NUM_DIGITS{1'b0}};
   localparam logic [NUM_DIGITS-1:0] D_ONES   = {NUM_DIGITS{1'b1}};
   localparam logic [NUM_DIGITS-1:0] D_LSB    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } frame_state_t;

   // Sampling / capture state
   logic [NUM_DIGITS-1:0]   last_an_r;
   logic [6:0]              last_seg_r;
   logic [CW-1:0]           cnt_r;
   logic [4*NUM_DIGITS-1:0] buf_r;
   logic [NUM_DIGITS-1:0]   err_buf_r;
   logic [NUM_DIGITS-1:0]   mask_r;

   // Frame side state
   frame_state_t            state_r;
   logic [4*NUM_DIGITS-1:0] frame_data_r;
   logic [NUM_DIGITS-1:0]   frame_err_r;
   logic                    overrun_r;

   logic [NUM_DIGITS-1:0]   sel_s;
   logic                    legal_s;
   logic                    sample_diff_s;
   logic [CW-1:0]           cnt_next_s;
   logic                    capture_s;
   logic [NUM_DIGITS-1:0]   wr_s;
   logic [NUM_DIGITS-1:0]   mask_next_s;
   logic                    complete_s;
   logic [4*NUM_DIGITS-1:0] buf_next_s;
   logic [NUM_DIGITS-1:0]   err_next_s;
   nibble_t                 dec_nib_s;
   logic                    dec_err_s;
   frame_state_t            state_next_s;
   logic                    load_s;
   logic                    drop_s;

`ifdef SEG7_SCAN_DP_EN
   logic                    last_dp_r;
   logic [NUM_DIGITS-1:0]   dp_buf_r;
   logic [NUM_DIGITS-1:0]   dp_next_s;
   logic [NUM_DIGITS-1:0]   frame_dp_r;
   assign sample_diff_s = (an_n_in != last_an_r) || (seg_in != last_seg_r) ||
                          (dp_in != last_dp_r);
   assign frame_dp      = frame_dp_r;
`else
   assign sample_diff_s = (an_n_in != last_an_r) || (seg_in != last_seg_r);
`endif

   // A select is legal only when exactly one anode is driven low.
   assign sel_s   = ~an_n_in;
   assign legal_s = (sel_s != D_ZERO) && ((sel_s & (sel_s - D_LSB)) == D_ZERO);

   seg7_glyph_decode u_decode (
      .seg    (seg_in),
      .nibble (dec_nib_s),
      .err    (dec_err_s)
   );

   // Stability counter next value: restart on change, park at the threshold.
   always_comb begin
      cnt_next_s = cnt_r;
      if (!legal_s) begin
         cnt_next_s = CNT_ZERO;
      end else if (sample_diff_s) begin
         cnt_next_s = CNT_ONE;
      end else if (cnt_r == CNT_MAX) begin
         cnt_next_s = CNT_MAX;
      end else begin
         cnt_next_s = cnt_r + CNT_ONE;
      end
   end

   // Capture fires once, on the step into the threshold; completion looks at
   // the next-state mask so the final digit's capture cycle completes the frame.
   assign capture_s   = (cnt_next_s == CNT_MAX) && (cnt_r != CNT_MAX);
   assign wr_s        = capture_s ? sel_s : D_ZERO;
   assign mask_next_s = mask_r | wr_s;
   assign complete_s  = (mask_next_s == D_ONES);

   // Buffer next state: write the decoded digit into the selected slot.
   always_comb begin
      buf_next_s = buf_r;
      err_next_s = err_buf_r;
`ifdef SEG7_SCAN_DP_EN
      dp_next_s  = dp_buf_r;
`endif
      for (int i = 0; i < NUM_DIGITS; i++) begin
         buf_next_s[4*i +: 4] = wr_s[i] ? dec_nib_s : buf_r[4*i +: 4];
         err_next_s[i]        = wr_s[i] ? dec_err_s : err_buf_r[i];
`ifdef SEG7_SCAN_DP_EN
         dp_next_s[i]         = wr_s[i] ? dp_in : dp_buf_r[i];
`endif
      end
   end

   // Frame FSM next state: load on completion when the output slot is free
   // or being accepted this cycle, otherwise drop and flag the overrun.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      drop_s       = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (complete_s) begin
               state_next_s = ST_FULL;
               load_s       = 1'b1;
            end else begin
               state_next_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (complete_s && frame_ready) begin
               state_next_s = ST_FULL;
               load_s       = 1'b1;
            end else if (complete_s) begin
               state_next_s = ST_FULL;
               drop_s       = 1'b1;
            end else if (frame_ready) begin
               state_next_s = ST_EMPTY;
            end else begin
               state_next_s = ST_FULL;
            end
         end
         default: begin
            state_next_s = ST_EMPTY;
         end
      endcase
   end

   // Frame FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Sample history, stability counter and partial-frame capture buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_an_r  <= D_ZERO;
         last_seg_r <= 7'h00;
         cnt_r      <= CNT_ZERO;
         buf_r      <= {(4*NUM_DIGITS){1'b0}};
         err_buf_r  <= D_ZERO;
         mask_r     <= D_ZERO;
`ifdef SEG7_SCAN_DP_EN
         last_dp_r  <= 1'b0;
         dp_buf_r   <= D_ZERO;
`endif
      end else begin
         last_an_r  <= an_n_in;
         last_seg_r <= seg_in;
         cnt_r      <= cnt_next_s;
         buf_r      <= buf_next_s;
         err_buf_r  <= err_next_s;
         mask_r     <= complete_s ? D_ZERO : mask_next_s;
`ifdef SEG7_SCAN_DP_EN
         last_dp_r  <= dp_in;
         dp_buf_r   <= dp_next_s;
`endif
      end
   end

   // Output frame registers and the sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_data_r <= {(4*NUM_DIGITS){1'b0}};
         frame_err_r  <= D_ZERO;
         overrun_r    <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
         frame_dp_r   <= D_ZERO;
`endif
      end else begin
         if (load_s) begin
            frame_data_r <= buf_next_s;
            frame_err_r  <= err_next_s;
`ifdef SEG7_SCAN_DP_EN
            frame_dp_r   <= dp_next_s;
`endif
         end
         overrun_r <= overrun_r | drop_s;
      end
   end

   assign frame_valid = (state_r == ST_FULL);
   assign frame_data  = frame_data_r;
   assign frame_err   = frame_err_r;
   assign overrun     = overrun_r;

endmodule
